// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared defaults, port-tag type and wrap helper for the ROM read arbiter.
package rom_arb_pkg;
  localparam int N_REQ_DEF      = 4;
  localparam int ADDR_WIDTH_DEF = 15;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int TAG_IDX_W      = 8;

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } port_tag_t;

  localparam port_tag_t PORT_NONE = '{vld: 1'b0, idx: '0};

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b >= n) ? a + b - n : a + b;
  endfunction
endpackage

// File: rtl/rr_pick_first.sv
// rr_pick_first: first set request at or after start, wrapping, with a found flag.
module rr_pick_first
  import rom_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          found
);
  logic [2*N-1:0] rot;

  always_comb begin
    rot   = {req, req} >> start;
    found = |req;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--)
      idx = rot[k] ? IW'(wrap_add(int'(start), k, N)) : idx;
  end
endmodule

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin sharing of a dual-port ROM among N_REQ readers, two grants per cycle.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [N_REQ*DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]         rom_addr1,
  output logic [ADDR_WIDTH-1:0]         rom_addr2,
  input  logic [DATA_WIDTH-1:0]         rom_q1,
  input  logic [DATA_WIDTH-1:0]         rom_q2
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;

  logic [IW-1:0]    rr_ptr_q, rr_ptr_d, w1, w2, start2;
  logic             f1, f2;
  logic [N_REQ-1:0] g1, g2, req2;
  port_tag_t        tag1_q, tag1_d, tag2_q, tag2_d;

  rr_pick_first #(.N(N_REQ)) u_pick1 (.req(req),  .start(rr_ptr_q), .idx(w1), .found(f1));
  rr_pick_first #(.N(N_REQ)) u_pick2 (.req(req2), .start(start2),   .idx(w2), .found(f2));

  // Port 2 searches after the port-1 winner with that winner removed, so no requester gets both.
  always_comb begin
    g1        = f1 ? N_REQ'(1) << w1 : '0;
    g2        = f2 ? N_REQ'(1) << w2 : '0;
    req2      = req & ~g1;
    start2    = IW'(wrap_add(int'(w1), 1, N_REQ));
    gnt       = rst ? '0 : g1 | g2;
    rom_addr1 = (f1 && !rst) ? addr[int'(w1)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    rom_addr2 = (f2 && !rst) ? addr[int'(w2)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    tag1_d    = (rst || !f1) ? PORT_NONE : '{vld: 1'b1, idx: TAG_IDX_W'(w1)};
    tag2_d    = (rst || !f2) ? PORT_NONE : '{vld: 1'b1, idx: TAG_IDX_W'(w2)};
    rr_ptr_d  = rst ? '0 :
                f2  ? IW'(wrap_add(int'(w2), 1, N_REQ)) :
                f1  ? IW'(wrap_add(int'(w1), 1, N_REQ)) : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    rr_ptr_q <= rr_ptr_d;
    tag1_q   <= tag1_d;
    tag2_q   <= tag2_d;
  end

  // Returning data is masked while rst is high so a read granted just before reset is dropped.
  for (genvar g = 0; g < N_REQ; g++) begin : g_out
    logic hit1, hit2;
    assign hit1 = tag1_q.vld && tag1_q.idx == TAG_IDX_W'(g);
    assign hit2 = tag2_q.vld && tag2_q.idx == TAG_IDX_W'(g);
    assign rvalid[g] = !rst && (hit1 || hit2);
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = rst  ? '0 :
                                               hit1 ? rom_q1 :
                                               hit2 ? rom_q2 : '0;
  end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb_rom_read_arbiter: directed and random stimulus against a behavioural ROM and round-robin model.
module tb_rom_read_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [59:0] addr;
  logic [3:0]  gnt, rvalid;
  logic [63:0] rdata;
  logic [14:0] rom_addr1, rom_addr2;
  logic [15:0] rom_q1, rom_q2;

  typedef struct {
    logic [3:0]  v;
    logic [63:0] d;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_ptr  = 0;

  always #5 clk = ~clk;

  rom_read_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .rom_addr1(rom_addr1), .rom_addr2(rom_addr2),
    .rom_q1(rom_q1), .rom_q2(rom_q2)
  );

  function automatic logic [15:0] rom_f(input logic [14:0] a);
    return a == 15'h0010 ? 16'hBEEF :
           a == 15'h7FFF ? 16'h1234 : {1'b0, a} ^ 16'hC3A5;
  endfunction

  always @(posedge clk) begin
    rom_q1 <= rom_f(rom_addr1);
    rom_q2 <= rom_f(rom_addr2);
  end

  function automatic logic [59:0] pack_a(input logic [14:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [59:0] a, input logic rs);
    exp_t        e, n;
    int          p1, p2;
    logic [3:0]  eg;
    logic [14:0] ea1, ea2;
    @(posedge clk);
    #1;
    req  = r;
    addr = a;
    rst  = rs;
    #1;
    e = sbq.pop_front();
    if (rs) begin
      e.v = '0;
      e.d = '0;
    end
    chk("rvalid", {60'd0, rvalid}, {60'd0, e.v});
    chk("rdata", rdata, e.d);
    p1 = -1;
    p2 = -1;
    if (!rs) begin
      for (int k = 0; k < 4; k++)
        if (p1 < 0 && r[(m_ptr + k) % 4]) p1 = (m_ptr + k) % 4;
      if (p1 >= 0)
        for (int k = 1; k < 4; k++)
          if (p2 < 0 && r[(p1 + k) % 4]) p2 = (p1 + k) % 4;
    end
    eg  = '0;
    ea1 = '0;
    ea2 = '0;
    n.v = '0;
    n.d = '0;
    if (p1 >= 0) begin
      eg[p1] = 1'b1;
      ea1 = a[p1*15 +: 15];
      n.v[p1] = 1'b1;
      n.d[p1*16 +: 16] = rom_f(ea1);
    end
    if (p2 >= 0) begin
      eg[p2] = 1'b1;
      ea2 = a[p2*15 +: 15];
      n.v[p2] = 1'b1;
      n.d[p2*16 +: 16] = rom_f(ea2);
    end
    chk("gnt", {60'd0, gnt}, {60'd0, eg});
    chk("rom_addr1", {49'd0, rom_addr1}, {49'd0, ea1});
    chk("rom_addr2", {49'd0, rom_addr2}, {49'd0, ea2});
    sbq.push_back(n);
    m_ptr = rs ? 0 : p2 >= 0 ? (p2 + 1) % 4 : p1 >= 0 ? (p1 + 1) % 4 : m_ptr;
  endtask

  initial begin
    exp_t       z;
    logic [3:0] seq[4];
    z.v  = '0;
    z.d  = '0;
    rst  = 1'b1;
    req  = '0;
    addr = '0;
    sbq.push_back(z);
    cycle(4'b1111, pack_a(1, 2, 3, 4), 1'b1);
    chk("rst_gnt", {60'd0, gnt}, 64'd0);
    cycle(4'b0000, '0, 1'b1);
    // single requester read with known ROM content
    cycle(4'b0001, pack_a(0, 0, 0, 15'h0010), 1'b0);
    chk("t034_gnt", {60'd0, gnt}, 64'h1);
    chk("t034_a1", {49'd0, rom_addr1}, 64'h10);
    cycle(4'b0000, '0, 1'b0);
    chk("t034_rv", {60'd0, rvalid}, 64'h1);
    chk("t034_rd0", {48'd0, rdata[15:0]}, 64'hBEEF);
    cycle(4'b0000, '0, 1'b1);
    // all four requesting from pointer 0
    seq = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, pack_a(15'(16 * i + 3), 15'(16 * i + 2), 15'(16 * i + 1), 15'(16 * i)), 1'b0);
      chk("t035_gnt", {60'd0, gnt}, {60'd0, seq[i]});
    end
    cycle(4'b0000, '0, 1'b0);
    chk("t035_rv_last", {60'd0, rvalid}, 64'hC);
    // same address on both ports
    cycle(4'b0101, pack_a(0, 15'h7FFF, 0, 15'h7FFF), 1'b0);
    chk("t036_gnt", {60'd0, gnt}, 64'h5);
    chk("t036_a1", {49'd0, rom_addr1}, 64'h7FFF);
    chk("t036_a2", {49'd0, rom_addr2}, 64'h7FFF);
    cycle(4'b0000, '0, 1'b0);
    chk("t036_rd0", {48'd0, rdata[15:0]}, 64'h1234);
    chk("t036_rd2", {48'd0, rdata[47:32]}, 64'h1234);
    // wrap from pointer 3
    cycle(4'b1001, pack_a(15'h0333, 0, 0, 15'h0444), 1'b0);
    chk("t037_gnt", {60'd0, gnt}, 64'h9);
    chk("t037_a1", {49'd0, rom_addr1}, 64'h333);
    chk("t037_a2", {49'd0, rom_addr2}, 64'h444);
    cycle(4'b1111, pack_a(7, 6, 5, 4), 1'b0);
    chk("t037_ptr1", {60'd0, gnt}, 64'h6);
    // read granted just before reset is discarded
    cycle(4'b0010, pack_a(0, 0, 15'h0055, 0), 1'b0);
    chk("t038_gnt", {60'd0, gnt}, 64'h2);
    cycle(4'b0010, pack_a(0, 0, 15'h0055, 0), 1'b1);
    chk("t038_rv_t1", {60'd0, rvalid}, 64'h0);
    chk("t038_gnt_rst", {60'd0, gnt}, 64'h0);
    cycle(4'b0000, '0, 1'b0);
    chk("t038_rv_t2", {60'd0, rvalid}, 64'h0);
    cycle(4'b1001, pack_a(15'h0AAA, 0, 0, 15'h0BBB), 1'b0);
    chk("t038_ptr0", {49'd0, rom_addr1}, 64'h0BBB);
    // random traffic, including address changes on waiting requesters
    for (int i = 0; i < 24; i++)
      cycle(4'($urandom), 60'({$urandom(), $urandom()}), 1'b0);
    // one requester streaming alone
    for (int i = 0; i < 8; i++) begin
      cycle(4'b0001, pack_a(0, 0, 0, 15'(15'h0100 + i)), 1'b0);
      chk("t039_gnt0", {63'd0, gnt[0]}, 64'h1);
      chk("t039_a2", {49'd0, rom_addr2}, 64'h0);
    end
    cycle(4'b0000, '0, 1'b0);
    chk("t039_rd_last", {48'd0, rdata[15:0]}, {48'd0, rom_f(15'h0107)});
    cycle(4'b0000, '0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of read requesters.
REQ-002 Parameter ADDR_WIDTH, default 15, ROM word-address width.
REQ-003 Parameter DATA_WIDTH, default 16, ROM word width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N_REQ  per-requester read request, level, held until granted.
REQ-007 addr  input  N_REQ*ADDR_WIDTH  per-requester word address, slice i = requester i, stable while req[i] high.
REQ-008 gnt  output  N_REQ  per-requester grant, combinational, one-hot per served port.
REQ-009 rvalid  output  N_REQ  per-requester read-data-valid strobe, registered.
REQ-010 rdata  output  N_REQ*DATA_WIDTH  per-requester read data, slice i valid when rvalid[i].
REQ-011 rom_addr1  output  ADDR_WIDTH  address to ROM port 1.
REQ-012 rom_addr2  output  ADDR_WIDTH  address to ROM port 2.
REQ-013 rom_q1  input  DATA_WIDTH  ROM port-1 data, registered in ROM, one cycle after address.
REQ-014 rom_q2  input  DATA_WIDTH  ROM port-2 data, registered in ROM, one cycle after address.

Function
REQ-015 Each cycle SHALL grant at most two requesters: port 1 to the first requester with req high searching upward from rr_ptr with wrap-around, port 2 to the next requester with req high after that one, also with wrap.
REQ-016 A requester SHALL never be granted both ports in one cycle.
REQ-017 gnt[i] SHALL be high in the same cycle its request is selected; requester may drop or change req/addr on the following cycle.
REQ-018 rom_addr1/rom_addr2 SHALL carry the granted requester's addr; an unused port SHALL be driven 0.
REQ-019 For each port, a registered tag (PORT_NONE or requester index) SHALL capture the grant at the posedge closing the grant cycle.
REQ-020 rvalid[i] SHALL be high exactly one cycle after gnt[i] (latency 1), for exactly one cycle per grant.
REQ-021 rdata slice i SHALL be rom_q1 when port-1 tag = i, rom_q2 when port-2 tag = i, else 0.
REQ-022 rr_ptr SHALL update after a granting cycle to (index of last granted requester + 1) mod N_REQ; with no grants rr_ptr holds.
REQ-023 A single continuously requesting requester SHALL be granted every cycle (throughput 1 read/cycle/requester, 2 reads/cycle total).
REQ-024 Two requesters presenting the same address SHALL both be granted on separate ports; no merging.
REQ-025 With all N_REQ requesting continuously, every requester SHALL be granted within ceil(N_REQ/2) cycles (starvation bound).
REQ-026 A change of addr while req is high and not yet granted SHALL be taken as the new address; no error flagged.

Reset
REQ-027 While rst high: gnt = 0, rom_addr1 = rom_addr2 = 0, no new grants.
REQ-028 At the posedge with rst high: rr_ptr <= 0, both port tags <= PORT_NONE, so rvalid = 0 and rdata = 0 the next cycle.
REQ-029 A read granted in the cycle before rst asserts SHALL be discarded: no rvalid is produced for it.
REQ-030 First grant possible in the first cycle with rst low.

Structure
REQ-031 Package rom_arb_pkg SHALL hold N_REQ, ADDR_WIDTH, DATA_WIDTH defaults and the port-tag type (index plus PORT_NONE encoding).
REQ-032 Sub-module rr_pick_first (find first set bit at or after a start index, with wrap, plus found flag) SHALL be instantiated twice: port 1 from rr_ptr, port 2 from port-1 winner + 1 with that winner masked.
REQ-033 No storage beyond rr_ptr and the two port tags.

Verification
REQ-034 req=0001, addr0=0x0010, ROM[0x0010]=0xBEEF -> gnt=0001 same cycle, rom_addr1=0x0010, rom_addr2=0, next cycle rvalid=0001, rdata0=0xBEEF.
REQ-035 req=1111 held 4 cycles from rr_ptr=0 -> gnt sequence 0011, 1100, 0011, 1100; rvalid follows one cycle later each.
REQ-036 req=0101, addr0=addr2=0x7FFF, ROM[0x7FFF]=0x1234 -> gnt=0101, both rom_addr=0x7FFF, next cycle rdata0=rdata2=0x1234.
REQ-037 rr_ptr=3, req=1001 -> port1 to requester 3, port2 to requester 0 (wrap), rr_ptr becomes 1.
REQ-038 req=0010 granted at cycle t, rst high at cycle t+1 -> rvalid=0 at t+1 and t+2, gnt=0 throughout rst, rr_ptr=0 after.
REQ-039 Requester 0 held high 8 cycles alone -> gnt[0] high all 8 cycles, 8 rvalid pulses with matching data, never on port 2.
